// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), CHUNK bits per clock.
// Latency: N = WIDTH/CHUNK cycles from the accepted start edge to done.
// Backpressure: start is ignored while busy; result/zero hold until the next completion.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   chunk_res;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic               last_chunk;

    assign last_chunk = (cnt_q == CW'(N - 1));

    // Bitwise op on the current low chunk of the operand shift registers
    always_comb begin
        chunk_res = '0;
        case (op_q)
            2'b00:   chunk_res = a_sh_q[CHUNK-1:0] & b_sh_q[CHUNK-1:0];
            2'b01:   chunk_res = a_sh_q[CHUNK-1:0] | b_sh_q[CHUNK-1:0];
            2'b10:   chunk_res = a_sh_q[CHUNK-1:0] ^ b_sh_q[CHUNK-1:0];
            default: chunk_res = ~(a_sh_q[CHUNK-1:0] | b_sh_q[CHUNK-1:0]);
        endcase
    end

    // Chunk results enter at the MSB end so that after N shifts chunk 0 lands in bits [CHUNK-1:0];
    // the single-chunk case has no remaining accumulator bits to keep.
    generate
        if (N == 1) begin : g_single
            assign acc_shift = chunk_res;
            assign a_nxt     = '0;
            assign b_nxt     = '0;
        end else begin : g_multi
            assign acc_shift = {chunk_res, acc_q[WIDTH-1:CHUNK]};
            assign a_nxt     = {{CHUNK{1'b0}}, a_sh_q[WIDTH-1:CHUNK]};
            assign b_nxt     = {{CHUNK{1'b0}}, b_sh_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept start in IDLE, leave RUN after the last chunk
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_chunk) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_RUN);
    end

    // Datapath next-state: capture on start, step one chunk per RUN cycle, publish at completion
    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    op_d   = op;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
            end
            S_RUN: begin
                a_sh_d = a_nxt;
                b_sh_d = b_nxt;
                acc_d  = acc_shift;
                cnt_d  = cnt_q + 1'b1;
                if (last_chunk) begin
                    result_d = acc_shift;
                    zero_d   = (acc_shift == '0);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: WIDTH=32, CHUNK=8
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    seq_logic_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    // WIDTH=16, CHUNK=4
    logic        start_s = 1'b0;
    logic [1:0]  op_s = 2'b00;
    logic [15:0] a_s = '0, b_s = '0;
    logic        busy_s, done_s, zero_s;
    logic [15:0] result_s;

    seq_logic_unit #(.WIDTH(16), .CHUNK(4)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .op(op_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .result(result_s), .zero(zero_s)
    );

    // WIDTH=32, CHUNK=32 (single cycle per operation)
    logic        start_w = 1'b0;
    logic [1:0]  op_w = 2'b00;
    logic [31:0] a_w = '0, b_w = '0;
    logic        busy_w, done_w, zero_w;
    logic [31:0] result_w;

    seq_logic_unit #(.WIDTH(32), .CHUNK(32)) u_dut_w (
        .clk(clk), .reset(reset), .start(start_w), .op(op_w), .a(a_w), .b(b_w),
        .busy(busy_w), .done(done_w), .result(result_w), .zero(zero_w)
    );

    exp_t exp_q[$];
    exp_t exp_s_q[$];
    exp_t exp_w_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Main monitor: checks each done against the scoreboard and that outputs hold in between
    int          busy_run = 0;
    logic [31:0] held = '0;
    logic        held_z = 1'b1;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            busy_run = 0;
            held     = '0;
            held_z   = 1'b1;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    cmp("result", result, e.res);
                    cmp("zero", {31'd0, zero}, {31'd0, e.z});
                    cmp("done_cycle", 32'(cyc), 32'(e.t));
                    cmp("busy_cycles", 32'(busy_run), 32'd4);
                    cmp("busy_in_done", {31'd0, busy}, 32'd0);
                    held   = e.res;
                    held_z = e.z;
                end
                busy_run = 0;
            end else begin
                cmp("held_result", result, held);
                cmp("held_zero", {31'd0, zero}, {31'd0, held_z});
            end
        end
    end

    // Monitors for the parameter-sweep instances
    exp_t es, ew;
    always @(negedge clk) begin
        if (!reset && done_s) begin
            if (exp_s_q.size() == 0) cmp("s_unexpected_done", 32'd1, 32'd0);
            else begin
                es = exp_s_q.pop_front();
                cmp("s_result", {16'd0, result_s}, es.res);
                cmp("s_zero", {31'd0, zero_s}, {31'd0, es.z});
                cmp("s_done_cycle", 32'(cyc), 32'(es.t));
            end
        end
        if (!reset && done_w) begin
            if (exp_w_q.size() == 0) cmp("w_unexpected_done", 32'd1, 32'd0);
            else begin
                ew = exp_w_q.pop_front();
                cmp("w_result", result_w, ew.res);
                cmp("w_zero", {31'd0, zero_w}, {31'd0, ew.z});
                cmp("w_done_cycle", 32'(cyc), 32'(ew.t));
            end
        end
    end

    // Issue one op on the main instance (called at a negedge); returns one cycle later
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expv);
        exp_t n;
        n.res = expv;
        n.z   = (expv == 32'd0);
        n.t   = cyc + 1 + 4;
        exp_q.push_back(n);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        exp_t n;
        // Reset values
        @(negedge clk);
        cmp("rst_busy", {31'd0, busy}, 32'd0);
        cmp("rst_done", {31'd0, done}, 32'd0);
        cmp("rst_result", result, 32'd0);
        cmp("rst_zero", {31'd0, zero}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // OR
        issue(2'b01, 32'd47, 32'd25, 32'd63);
        repeat (5) @(negedge clk);
        issue(2'b01, 32'h42220225, 32'h4002028A, 32'h422202AF);
        repeat (5) @(negedge clk);
        // AND / XOR / NOR
        issue(2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        repeat (5) @(negedge clk);
        issue(2'b10, 32'h12345678, 32'h12345678, 32'h00000000);
        repeat (5) @(negedge clk);
        issue(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);

        // Start pulsed mid-RUN with different operands: must be ignored
        issue(2'b01, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        @(negedge clk);
        op = 2'b10; a = 32'hDEADBEEF; b = 32'h01234567; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // Start held high: three ops back to back, every 5 cycles
        for (int i = 0; i < 3; i++) begin
            n.res = 32'hF000F000;
            n.z   = 1'b0;
            n.t   = cyc + 5 + 5 * i;
            exp_q.push_back(n);
        end
        op = 2'b00; a = 32'hF0F0F0F0; b = 32'hFF00FF00; start = 1'b1;
        repeat (15) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset when cnt==2
        issue(2'b01, 32'h11111111, 32'h22222222, 32'h33333333);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        cmp("midrst_busy", {31'd0, busy}, 32'd0);
        cmp("midrst_done", {31'd0, done}, 32'd0);
        cmp("midrst_result", result, 32'd0);
        cmp("midrst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        issue(2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA);
        repeat (5) @(negedge clk);

        // Parameter sweep instances
        n.res = 32'h0000AA55; n.z = 1'b0; n.t = cyc + 1 + 4;
        exp_s_q.push_back(n);
        op_s = 2'b10; a_s = 16'hA5A5; b_s = 16'h0FF0; start_s = 1'b1;
        n.res = 32'd63; n.z = 1'b0; n.t = cyc + 1 + 1;
        exp_w_q.push_back(n);
        op_w = 2'b01; a_w = 32'd47; b_w = 32'd25; start_w = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_w = 1'b0;
        repeat (6) @(negedge clk);

        // Every expected completion must have been observed
        cmp("pending_main", 32'(exp_q.size()), 32'd0);
        cmp("pending_s", 32'(exp_s_q.size()), 32'd0);
        cmp("pending_w", 32'(exp_w_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
